dds_param_scheduler: RTL

Timed parameter scheduler that sits directly upstream of the DDS phase MAC. It queues frequency/phase commands tagged with a 48-bit execution timestamp and owns the free-running timestamp counter. At the scheduled tick it presents the new time offset, frequency, phase and accumulated phase to the MAC. In continuous mode it carries the running phase across the update so that phase stays continuous across frequency changes.

---
 rtl/dds_sched_pkg.sv | 22 ++
 rtl/sched_cmd_fifo.sv | 71 +++++++
 rtl/dds_param_scheduler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dds_sched_pkg.sv
// Shared types for the timed DDS parameter scheduler: the queued command record
// and the scheduler FSM states.
package dds_sched_pkg;

  localparam int TS_W_DEF = 48;
  localparam int PH_W_DEF = 14;

  typedef struct packed {
    logic [TS_W_DEF-1:0] timestamp;
    logic [TS_W_DEF-1:0] freq;
    logic [PH_W_DEF-1:0] phase;
    logic                continuous;
  } sched_cmd_t;

  // Applying a command happens on the edge that leaves WAIT, so there is no
  // dwell state for it.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } sched_state_t;

endpackage

// File: rtl/sched_cmd_fifo.sv
// First-word-fall-through command FIFO: the head entry is visible on dout while
// the FIFO is non-empty. Push while full and pop while empty are ignored.
module sched_cmd_fifo
  import dds_sched_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  sched_cmd_t    din,
  input  logic          pop,
  output sched_cmd_t    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  sched_cmd_t    mem_q [DEPTH];
  sched_cmd_t    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/dds_param_scheduler.sv
// Timed parameter scheduler feeding the DDS phase MAC: owns the timestamp counter
// and running phase, and loads queued frequency/phase commands at their tick.
module dds_param_scheduler
  import dds_sched_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  TS_W  = TS_W_DEF,
  parameter int  PH_W  = PH_W_DEF,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            counter_clear,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [TS_W-1:0] cmd_timestamp,
  input  logic [TS_W-1:0] cmd_freq,
  input  logic [PH_W-1:0] cmd_phase,
  input  logic            cmd_continuous,
  output logic [TS_W-1:0] time_offset,
  output logic [TS_W-1:0] freq,
  output logic [PH_W-1:0] phase,
  output logic [TS_W-1:0] timestamp,
  output logic [TS_W-1:0] acc_phase,
  output logic            apply_pulse,
  output logic            late_pulse,
  output logic            late_flag,
  output logic [CW-1:0]   fifo_count
);

  sched_state_t    state_q, state_d;
  logic [TS_W-1:0] cnt_q, cnt_d;
  logic [TS_W-1:0] r_q, r_d;
  logic [TS_W-1:0] time_offset_q, time_offset_d;
  logic [TS_W-1:0] freq_q, freq_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [TS_W-1:0] acc_phase_q, acc_phase_d;
  logic            apply_pulse_q, apply_pulse_d;
  logic            late_pulse_q, late_pulse_d;
  logic            late_flag_q, late_flag_d;

  sched_cmd_t      cmd_in, head;
  logic            fifo_full, fifo_empty;
  logic            push, on_time, late, apply, waiting;
  logic [TS_W-1:0] cnt_inc, r_step, acc_new;

  sched_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (cmd_in),
    .pop   (apply),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    cmd_in.timestamp  = cmd_timestamp;
    cmd_in.freq       = cmd_freq;
    cmd_in.phase      = cmd_phase;
    cmd_in.continuous = cmd_continuous;
    push    = cmd_valid && !fifo_full;
    cnt_inc = cnt_q + TS_W'(1);
    r_step  = r_q + freq_q;
    waiting = (state_q == WAIT) && !fifo_empty;
    // On-time loads land on the edge where the counter reaches H, so the MAC
    // sees the new parameters in the same cycle as timestamp == H.
    on_time = waiting && run && (cnt_inc == head.timestamp);
    late    = waiting && !on_time && (head.timestamp <= cnt_q);
    apply   = on_time || late;
    acc_new = head.continuous ? r_step : '0;

    cnt_d = cnt_q;
    r_d   = r_q;
    if (run) begin
      cnt_d = cnt_inc;
      r_d   = r_step;
    end
    if (apply) begin
      r_d = acc_new;
    end
    if (counter_clear) begin
      cnt_d = '0;
      r_d   = '0;
    end

    time_offset_d = time_offset_q;
    freq_d        = freq_q;
    phase_d       = phase_q;
    acc_phase_d   = acc_phase_q;
    if (apply) begin
      time_offset_d = on_time ? head.timestamp : cnt_q + TS_W'(run);
      freq_d        = head.freq;
      phase_d       = head.phase;
      acc_phase_d   = acc_new;
    end
    apply_pulse_d = apply;
    late_pulse_d  = late;
    late_flag_d   = late_flag_q || late;
    state_d       = (push || (fifo_count > CW'(apply))) ? WAIT : IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      r_q           <= '0;
      time_offset_q <= '0;
      freq_q        <= '0;
      phase_q       <= '0;
      acc_phase_q   <= '0;
      apply_pulse_q <= 1'b0;
      late_pulse_q  <= 1'b0;
      late_flag_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      r_q           <= r_d;
      time_offset_q <= time_offset_d;
      freq_q        <= freq_d;
      phase_q       <= phase_d;
      acc_phase_q   <= acc_phase_d;
      apply_pulse_q <= apply_pulse_d;
      late_pulse_q  <= late_pulse_d;
      late_flag_q   <= late_flag_d;
    end
  end

  assign cmd_ready   = !fifo_full;
  assign time_offset = time_offset_q;
  assign freq        = freq_q;
  assign phase       = phase_q;
  assign timestamp   = cnt_q;
  assign acc_phase   = acc_phase_q;
  assign apply_pulse = apply_pulse_q;
  assign late_pulse  = late_pulse_q;
  assign late_flag   = late_flag_q;

endmodule
